fft_8: RTL and testbench



---
 rtl/fft_8.sv | 169 ++++++++++++++++
 tb/tb_fft_8.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fft_8.sv
// Pipelined 8-point radix-2 DIT FFT: one transform per enabled clock, three register stages.
// Each stage bank loads only with its valid bit; outputs hold the last result otherwise.
module fft_8 (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic signed [23:0] x0_real,
  input  logic signed [23:0] x1_real,
  input  logic signed [23:0] x2_real,
  input  logic signed [23:0] x3_real,
  input  logic signed [23:0] x4_real,
  input  logic signed [23:0] x5_real,
  input  logic signed [23:0] x6_real,
  input  logic signed [23:0] x7_real,
  input  logic signed [23:0] x0_imag,
  input  logic signed [23:0] x1_imag,
  input  logic signed [23:0] x2_imag,
  input  logic signed [23:0] x3_imag,
  input  logic signed [23:0] x4_imag,
  input  logic signed [23:0] x5_imag,
  input  logic signed [23:0] x6_imag,
  input  logic signed [23:0] x7_imag,
  output logic               valid,
  output logic signed [23:0] y0_real,
  output logic signed [23:0] y1_real,
  output logic signed [23:0] y2_real,
  output logic signed [23:0] y3_real,
  output logic signed [23:0] y4_real,
  output logic signed [23:0] y5_real,
  output logic signed [23:0] y6_real,
  output logic signed [23:0] y7_real,
  output logic signed [23:0] y0_imag,
  output logic signed [23:0] y1_imag,
  output logic signed [23:0] y2_imag,
  output logic signed [23:0] y3_imag,
  output logic signed [23:0] y4_imag,
  output logic signed [23:0] y5_imag,
  output logic signed [23:0] y6_imag,
  output logic signed [23:0] y7_imag
);

  localparam logic signed [15:0] C = 16'sd23170;
  localparam int PA [4] = '{0, 2, 1, 3};

  logic signed [23:0] xr [8];
  logic signed [23:0] xi [8];
  logic signed [23:0] yr [8];
  logic signed [23:0] yi [8];
  logic signed [24:0] s1r_d [8], s1i_d [8], s1r [8], s1i [8];
  logic signed [25:0] s2r_d [8], s2i_d [8], s2r [8], s2i [8];
  logic signed [27:0] zr [8], zi [8];
  logic signed [27:0] tr [4], ti [4];
  logic signed [26:0] sum5, dif5, sum7, dif7;
  logic               v1, v2;

  assign xr[0] = x0_real;  assign xi[0] = x0_imag;
  assign xr[1] = x1_real;  assign xi[1] = x1_imag;
  assign xr[2] = x2_real;  assign xi[2] = x2_imag;
  assign xr[3] = x3_real;  assign xi[3] = x3_imag;
  assign xr[4] = x4_real;  assign xi[4] = x4_imag;
  assign xr[5] = x5_real;  assign xi[5] = x5_imag;
  assign xr[6] = x6_real;  assign xi[6] = x6_imag;
  assign xr[7] = x7_real;  assign xi[7] = x7_imag;

  assign y0_real = yr[0];  assign y0_imag = yi[0];
  assign y1_real = yr[1];  assign y1_imag = yi[1];
  assign y2_real = yr[2];  assign y2_imag = yi[2];
  assign y3_real = yr[3];  assign y3_imag = yi[3];
  assign y4_real = yr[4];  assign y4_imag = yi[4];
  assign y5_real = yr[5];  assign y5_imag = yi[5];
  assign y6_real = yr[6];  assign y6_imag = yi[6];
  assign y7_real = yr[7];  assign y7_imag = yi[7];

  // v * c/2^15 with round-half-up; |v| < 2^26 keeps the product inside 43 bits.
  function automatic logic signed [27:0] twid(input logic signed [26:0] v);
    logic signed [42:0] p;
    p = 43'(v) * 43'(C) + 43'(16384);
    return 28'(p >>> 15);
  endfunction

  function automatic logic signed [23:0] sat(input logic signed [27:0] v);
    logic signed [23:0] r;
    if (v > 28'sh07FFFFF)      r = 24'sh7FFFFF;
    else if (v < 28'shF800000) r = 24'sh800000;
    else                       r = v[23:0];
    return r;
  endfunction

  // Stage 1: bit-reversed pairs (0,4),(2,6),(1,5),(3,7) -> sum at even slot, difference at odd.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      s1r_d[2*p]   = 25'(xr[PA[p]]) + 25'(xr[PA[p]+4]);
      s1r_d[2*p+1] = 25'(xr[PA[p]]) - 25'(xr[PA[p]+4]);
      s1i_d[2*p]   = 25'(xi[PA[p]]) + 25'(xi[PA[p]+4]);
      s1i_d[2*p+1] = 25'(xi[PA[p]]) - 25'(xi[PA[p]+4]);
    end
  end

  // Stage 2: -j twiddle on the odd difference term is a swap plus negate.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      s2r_d[4*g]   = 26'(s1r[4*g]) + 26'(s1r[4*g+2]);
      s2i_d[4*g]   = 26'(s1i[4*g]) + 26'(s1i[4*g+2]);
      s2r_d[4*g+2] = 26'(s1r[4*g]) - 26'(s1r[4*g+2]);
      s2i_d[4*g+2] = 26'(s1i[4*g]) - 26'(s1i[4*g+2]);
      s2r_d[4*g+1] = 26'(s1r[4*g+1]) + 26'(s1i[4*g+3]);
      s2i_d[4*g+1] = 26'(s1i[4*g+1]) - 26'(s1r[4*g+3]);
      s2r_d[4*g+3] = 26'(s1r[4*g+1]) - 26'(s1i[4*g+3]);
      s2i_d[4*g+3] = 26'(s1i[4*g+1]) + 26'(s1r[4*g+3]);
    end
  end

  // Stage 3: W^0, W^1 = c(1-j), W^2 = -j, W^3 = -c(1+j) applied to the upper half.
  always_comb begin
    sum5  = 27'(s2r[5]) + 27'(s2i[5]);
    dif5  = 27'(s2i[5]) - 27'(s2r[5]);
    sum7  = 27'(s2r[7]) + 27'(s2i[7]);
    dif7  = 27'(s2i[7]) - 27'(s2r[7]);
    tr[0] = 28'(s2r[4]);
    ti[0] = 28'(s2i[4]);
    tr[1] = twid(sum5);
    ti[1] = twid(dif5);
    tr[2] = 28'(s2i[6]);
    ti[2] = -28'(s2r[6]);
    tr[3] = twid(dif7);
    ti[3] = -twid(sum7);
    for (int k = 0; k < 4; k++) begin
      zr[k]   = 28'(s2r[k]) + tr[k];
      zi[k]   = 28'(s2i[k]) + ti[k];
      zr[k+4] = 28'(s2r[k]) - tr[k];
      zi[k+4] = 28'(s2i[k]) - ti[k];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      valid <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        s1r[k] <= '0;
        s1i[k] <= '0;
        s2r[k] <= '0;
        s2i[k] <= '0;
        yr[k]  <= '0;
        yi[k]  <= '0;
      end
    end else begin
      v1    <= en;
      v2    <= v1;
      valid <= v2;
      for (int k = 0; k < 8; k++) begin
        if (en) begin
          s1r[k] <= s1r_d[k];
          s1i[k] <= s1i_d[k];
        end
        if (v1) begin
          s2r[k] <= s2r_d[k];
          s2i[k] <= s2i_d[k];
        end
        if (v2) begin
          yr[k] <= sat(zr[k]);
          yi[k] <= sat(zi[k]);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_8.sv
// Directed bench for fft_8: reset, table of hand-computed transforms, hold, streaming, mid-run reset.
module tb_fft_8;

  typedef struct {
    logic [7:0][23:0] xr, xi, yr, yi;
  } vec_t;

  logic        clk, rstn, en;
  logic [23:0] xr [8];
  logic [23:0] xi [8];
  wire  [23:0] yr [8];
  wire  [23:0] yi [8];
  wire         valid;
  int          n_chk, n_fail;
  vec_t        tbl [7];

  fft_8 dut (
    .clk(clk), .rstn(rstn), .en(en),
    .x0_real(xr[0]), .x1_real(xr[1]), .x2_real(xr[2]), .x3_real(xr[3]),
    .x4_real(xr[4]), .x5_real(xr[5]), .x6_real(xr[6]), .x7_real(xr[7]),
    .x0_imag(xi[0]), .x1_imag(xi[1]), .x2_imag(xi[2]), .x3_imag(xi[3]),
    .x4_imag(xi[4]), .x5_imag(xi[5]), .x6_imag(xi[6]), .x7_imag(xi[7]),
    .valid(valid),
    .y0_real(yr[0]), .y1_real(yr[1]), .y2_real(yr[2]), .y3_real(yr[3]),
    .y4_real(yr[4]), .y5_real(yr[5]), .y6_real(yr[6]), .y7_real(yr[7]),
    .y0_imag(yi[0]), .y1_imag(yi[1]), .y2_imag(yi[2]), .y3_imag(yi[3]),
    .y4_imag(yi[4]), .y5_imag(yi[5]), .y6_imag(yi[6]), .y7_imag(yi[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] s24(input int v);
    return v[23:0];
  endfunction

  task automatic cmp(input string name, input integer act, input integer exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bins(input vec_t v, input string tag);
    for (int k = 0; k < 8; k++) begin
      cmp($sformatf("%s y%0d_real", tag, k), int'($signed(yr[k])), int'($signed(v.yr[k])));
      cmp($sformatf("%s y%0d_imag", tag, k), int'($signed(yi[k])), int'($signed(v.yi[k])));
    end
  endtask

  task automatic drive(input vec_t v);
    for (int k = 0; k < 8; k++) begin
      xr[k] = v.xr[k];
      xi[k] = v.xi[k];
    end
  endtask

  task automatic drive_rand();
    for (int k = 0; k < 8; k++) begin
      xr[k] = 24'($urandom());
      xi[k] = 24'($urandom());
    end
  endtask

  initial begin
    int t1r [8] = '{10000, 7071, 0, -7071, -10000, -7071, 0, 7071};
    int t1i [8] = '{0, -7071, -10000, -7071, 0, 7071, 10000, 7071};
    int t2r [8] = '{100, 0, -100, 0, 100, 0, -100, 0};
    int t2i [8] = '{0, -100, 0, 100, 0, -100, 0, 100};
    int t3r [8] = '{10000, -7071, 0, 7071, -10000, 7071, 0, -7071};
    int t3i [8] = '{0, -7071, 10000, -7071, 0, 7071, -10000, 7071};
    vec_t z;
    n_chk = 0;
    n_fail = 0;

    for (int i = 0; i < 7; i++) begin
      tbl[i].xr = '0; tbl[i].xi = '0; tbl[i].yr = '0; tbl[i].yi = '0;
    end
    for (int n = 0; n < 8; n++) begin
      tbl[0].xr[n] = s24(10 * (n % 4 + 1));
      tbl[1].yr[n] = s24(t1r[n]);  tbl[1].yi[n] = s24(t1i[n]);
      tbl[2].yr[n] = s24(t2r[n]);  tbl[2].yi[n] = s24(t2i[n]);
      tbl[3].yr[n] = s24(t3r[n]);  tbl[3].yi[n] = s24(t3i[n]);
      tbl[4].xr[n] = s24(4194303);
      tbl[5].xr[n] = s24(-4194304);
      tbl[6].yr[n] = s24(5);       tbl[6].yi[n] = s24(-3);
    end
    tbl[0].yr[0] = s24(200);
    tbl[0].yr[2] = s24(-40); tbl[0].yi[2] = s24(40);
    tbl[0].yr[4] = s24(-40);
    tbl[0].yr[6] = s24(-40); tbl[0].yi[6] = s24(-40);
    tbl[1].xr[1] = s24(10000);
    tbl[2].xr[2] = s24(100);
    tbl[3].xr[3] = s24(10000);
    tbl[4].yr[0] = s24(8388607);
    tbl[5].yr[0] = s24(-8388608);
    tbl[6].xr[0] = s24(5);   tbl[6].xi[0] = s24(-3);
    z.xr = '0; z.xi = '0; z.yr = '0; z.yi = '0;

    // Reset held with en=1 and noisy inputs: nothing may leak through.
    rstn = 1'b0;
    en = 1'b1;
    drive_rand();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_rand();
    end
    cmp("reset valid", valid, 0);
    check_bins(z, "reset");
    rstn = 1'b1;
    en = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      drive_rand();
      cmp($sformatf("vec%0d valid c1", i), valid, 0);
      @(negedge clk);
      cmp($sformatf("vec%0d valid c2", i), valid, 0);
      @(negedge clk);
      cmp($sformatf("vec%0d valid c3", i), valid, 1);
      check_bins(tbl[i], $sformatf("vec%0d", i));
    end

    // en pattern 1,0,0,1: outputs hold the first result through the gap.
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t >= 1) cmp($sformatf("hold valid t%0d", t), valid, (t == 3 || t == 6) ? 1 : 0);
      if (t >= 3 && t <= 5) check_bins(tbl[1], $sformatf("hold A t%0d", t));
      if (t >= 6) check_bins(tbl[3], $sformatf("hold B t%0d", t));
      if (t == 0) begin drive(tbl[1]); en = 1'b1; end
      else if (t == 3) begin drive(tbl[3]); en = 1'b1; end
      else begin drive_rand(); en = 1'b0; end
    end

    // Streaming ramp: 20 back-to-back transforms.
    for (int t = 0; t < 26; t++) begin
      @(negedge clk);
      cmp($sformatf("stream valid t%0d", t), valid, (t >= 3 && t < 23) ? 1 : 0);
      if (t >= 3 && t < 23) begin
        cmp($sformatf("stream y0_real t%0d", t), int'($signed(yr[0])), 8 * (100 + t - 3));
        cmp($sformatf("stream y0_imag t%0d", t), int'($signed(yi[0])), 0);
        for (int k = 1; k < 8; k++) begin
          cmp($sformatf("stream y%0d_real t%0d", k, t), int'($signed(yr[k])), 0);
          cmp($sformatf("stream y%0d_imag t%0d", k, t), int'($signed(yi[k])), 0);
        end
      end
      if (t < 20) begin
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
          xr[k] = s24(100 + t);
          xi[k] = '0;
        end
      end else begin
        en = 1'b0;
        drive_rand();
      end
    end

    // Asynchronous reset with a transform in flight.
    @(negedge clk);
    drive(tbl[0]);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    cmp("midreset valid", valid, 0);
    cmp("midreset y0_real", int'($signed(yr[0])), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cmp($sformatf("post-reset valid c%0d", c), valid, 0);
    end
    check_bins(z, "post-reset");
    drive(tbl[2]);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    cmp("post-reset first valid c2", valid, 0);
    @(negedge clk);
    cmp("post-reset first valid c3", valid, 1);
    check_bins(tbl[2], "post-reset vec2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
